// File: rtl/remote_cmd_sched.sv
// remote_cmd_sched: host-side command sequencer for the RemoteComm master UART.
// Queues {cmd, data} pairs and issues them one at a time over the send_cmd/cmd_sent/resp_rdy
// handshake. Each response is checked for the positive ack 8'hA5, and each command has a
// response timeout (CALIBRATE, 8'h06, gets CAL_TMO; every other opcode gets RESP_TMO).
//
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   push/push_cmd/push_data  enqueue one entry (ignored while q_full)
//   q_full, q_empty       queue occupancy flags
//   cmd, data             registered head entry presented to RemoteComm
//   send_cmd              one-cycle strobe starting a transfer
//   cmd_sent              RemoteComm frame transmitted (level)
//   resp_rdy, resp        response byte valid / value
//   clr_resp_rdy          one-cycle knock-down of resp_rdy after capture
//   busy                  command in flight
//   done, err             one-cycle retire pulses (ack / failure)
//   err_code              00 none, 01 NAK, 10 timeout; held until next err
//   last_resp             last captured response byte
//
// Build option: define SCHED_RETRY_EN to resend a failed head entry up to MAX_RETRY times
// before reporting err. Without it the first NAK/timeout errors immediately.
module remote_cmd_sched #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned RESP_TMO  = 1000000,
   parameter int unsigned CAL_TMO   = 4000000,
   parameter int unsigned MAX_RETRY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic [7:0]  push_cmd,
   input  logic [15:0] push_data,
   output logic        q_full,
   output logic        q_empty,
   output logic [7:0]  cmd,
   output logic [15:0] data,
   output logic        send_cmd,
   input  logic        cmd_sent,
   input  logic        resp_rdy,
   input  logic [7:0]  resp,
   output logic        clr_resp_rdy,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [7:0]  last_resp
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned TMO_MAX = (RESP_TMO > CAL_TMO) ? RESP_TMO : CAL_TMO;
   localparam int unsigned TW      = $clog2(TMO_MAX) + 1;
   localparam logic [7:0]  CmdCal  = 8'h06;
   localparam logic [7:0]  RespAck = 8'hA5;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least 2");
   end
   if (MAX_RETRY > 255) begin : g_bad_retry
      $error("MAX_RETRY out of range");
   end

   typedef enum logic [2:0] {
      StIdle, StIssue, StWaitSent, StWaitResp, StClr, StRetire
   } state_e;

   state_e          state_q;
   logic [23:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     cnt_q;
   logic [TW-1:0]   tmo_cnt_q;
   logic [TW-1:0]   tmo_lim;
   logic            push_ok, pop, tmo_hit, nak, fail, retry;

`ifdef SCHED_RETRY_EN
   localparam int unsigned RW = $clog2(MAX_RETRY + 1) + 1;
   logic [RW-1:0]   retry_cnt_q;
`endif

   // ---------------- queue ----------------
   assign q_full  = (cnt_q == (AW+1)'(DEPTH));
   assign q_empty = (cnt_q == '0);
   assign push_ok = push && !q_full;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr_q] <= {push_cmd, push_data};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push_ok, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- retire decisions ----------------
   always_comb begin
      tmo_lim = (cmd == CmdCal) ? TW'(CAL_TMO - 1) : TW'(RESP_TMO - 1);
      // A response arriving on the expiry cycle takes priority over the timeout.
      tmo_hit = ((state_q == StWaitSent) || (state_q == StWaitResp && !resp_rdy)) &&
                (tmo_cnt_q >= tmo_lim);
      nak     = (state_q == StRetire) && (last_resp != RespAck);
      fail    = tmo_hit || nak;
`ifdef SCHED_RETRY_EN
      retry   = fail && (retry_cnt_q < RW'(MAX_RETRY));
`else
      retry   = 1'b0;
`endif
      pop     = ((state_q == StRetire) && (last_resp == RespAck)) || (fail && !retry);
   end

   assign busy = (state_q != StIdle);

   // ---------------- sequencer ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         tmo_cnt_q    <= '0;
         cmd          <= '0;
         data         <= '0;
         send_cmd     <= 1'b0;
         clr_resp_rdy <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         err_code     <= 2'b00;
         last_resp    <= '0;
`ifdef SCHED_RETRY_EN
         retry_cnt_q  <= '0;
`endif
      end else begin
         send_cmd     <= 1'b0;
         clr_resp_rdy <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         if (fail) begin
            if (retry) begin
`ifdef SCHED_RETRY_EN
               retry_cnt_q <= retry_cnt_q + 1'b1;
`endif
               send_cmd <= 1'b1;
               state_q  <= StIssue;
            end else begin
               err      <= 1'b1;
               err_code <= tmo_hit ? 2'b10 : 2'b01;
`ifdef SCHED_RETRY_EN
               retry_cnt_q <= '0;
`endif
               state_q  <= StIdle;
            end
         end else begin
            unique case (state_q)
               StIdle: begin
                  // Hold off one cycle while a retire pulse is showing, so a new issue
                  // never lands closer than two cycles after done/err.
                  if (!q_empty && !done && !err) begin
                     {cmd, data} <= mem[rd_ptr_q];
                     send_cmd    <= 1'b1;
                     state_q     <= StIssue;
                  end
               end
               StIssue: begin
                  tmo_cnt_q <= '0;
                  state_q   <= StWaitSent;
               end
               StWaitSent: begin
                  if (tmo_cnt_q != '1) tmo_cnt_q <= tmo_cnt_q + 1'b1;
                  if (cmd_sent) state_q <= StWaitResp;
               end
               StWaitResp: begin
                  if (resp_rdy) begin
                     last_resp    <= resp;
                     clr_resp_rdy <= 1'b1;
                     state_q      <= StClr;
                  end else if (tmo_cnt_q != '1) begin
                     tmo_cnt_q <= tmo_cnt_q + 1'b1;
                  end
               end
               StClr: state_q <= StRetire;
               StRetire: begin
                  // Only the ack case reaches here; a NAK takes the fail branch above.
                  done    <= 1'b1;
`ifdef SCHED_RETRY_EN
                  retry_cnt_q <= '0;
`endif
                  state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
